// File: rtl/cr_sysio_irq_sync.sv
// Synchronises the IRQ/NMI pads, the system counter and the low-power mode into
// the forever_cpuclk domain. Optional glitch filter enabled by SYSIO_IRQ_FILTER_EN.
module cr_sysio_irq_sync #(
  parameter int IRQ_NUM     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 64,
  parameter int FILTER_LEN  = 3
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 clk_en,
  input  logic [IRQ_NUM-1:0]   pad_cpu_irq,
  input  logic [IRQ_NUM-1:0]   cp0_sysio_irq_mode,
  input  logic [IRQ_NUM-1:0]   cp0_sysio_irq_clr,
  output logic [IRQ_NUM-1:0]   sysio_clint_irq_pend,
  input  logic                 pad_cpu_nmi,
  input  logic                 iu_sysio_nmi_ack,
  output logic                 sysio_iu_nmi_int,
  input  logic [CNT_WIDTH-1:0] pad_cpu_sys_cnt,
  output logic [CNT_WIDTH-1:0] sysio_clint_mtime,
  input  logic [1:0]           cp0_sysio_lpmd_b,
  output logic [1:0]           sysio_pad_lpmd_b,
  output logic                 sysio_iu_wk_event
);

  // Bit IRQ_NUM of every per-line vector below is the NMI path.
  localparam int N = IRQ_NUM + 1;

  if (IRQ_NUM < 1 || IRQ_NUM > 32) begin : g_bad_irq_num
    $error("IRQ_NUM out of range 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("SYNC_STAGES out of range 2..4");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("FILTER_LEN out of range 1..15");
  end

  logic [N-1:0]         sync_chain_q [SYNC_STAGES];
  logic [N-1:0]         sync_val;
  logic [N-1:0]         filt_val;
  logic [N-1:0]         prv_q;
  logic [N-1:0]         edge_det;
  logic [IRQ_NUM-1:0]   pend_q, pend_d, level_d, edge_d;
  logic                 nmi_pend_q, nmi_pend_d;
  logic [CNT_WIDTH-1:0] mtime_q;
  logic [1:0]           lpmd_q;
  logic                 wk_q;

  // Free-running synchroniser; clk_en only qualifies what is done with sync_val.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      // NOTE: the chains are reset like any other flop so no stale pad level
      // can produce a spurious edge right after reset is released.
      for (int s = 0; s < SYNC_STAGES; s++) sync_chain_q[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this loop into a shift chain.
      sync_chain_q[0] <= {pad_cpu_nmi, pad_cpu_irq};
      for (int s = 1; s < SYNC_STAGES; s++) sync_chain_q[s] <= sync_chain_q[s-1];
    end
  end

  assign sync_val = sync_chain_q[SYNC_STAGES-1];

`ifdef SYSIO_IRQ_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0] flt_cnt_q [N];
  logic [FW-1:0] flt_cnt_d [N];
  logic [N-1:0]  filt_q, filt_d;

  always_comb begin
    // NOTE: defaults first, so every path leaves every bit assigned and no
    // latch is inferred.
    filt_d = filt_q;
    for (int i = 0; i < N; i++) begin
      flt_cnt_d[i] = flt_cnt_q[i];
      if (clk_en) begin
        if (sync_val[i] != filt_q[i]) begin
          if (flt_cnt_q[i] == FW'(FILTER_LEN - 1)) begin
            filt_d[i]    = sync_val[i];
            flt_cnt_d[i] = '0;
          end else begin
            flt_cnt_d[i] = flt_cnt_q[i] + FW'(1);
          end
        end else begin
          flt_cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      filt_q <= '0;
      for (int i = 0; i < N; i++) flt_cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < N; i++) flt_cnt_q[i] <= flt_cnt_d[i];
    end
  end

  assign filt_val = filt_q;
`else
  assign filt_val = sync_val;
`endif

  assign edge_det = filt_val & ~prv_q;

  // Level channels track the filtered line; edge channels latch until cleared,
  // with a fresh edge beating a coincident clear.
  assign level_d    = clk_en ? filt_val[IRQ_NUM-1:0] : pend_q;
  assign edge_d     = ({IRQ_NUM{clk_en}} & edge_det[IRQ_NUM-1:0]) | (pend_q & ~cp0_sysio_irq_clr);
  assign pend_d     = (cp0_sysio_irq_mode & edge_d) | (~cp0_sysio_irq_mode & level_d);
  assign nmi_pend_d = (clk_en & edge_det[IRQ_NUM]) | (nmi_pend_q & ~iu_sysio_nmi_ack);

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      prv_q      <= '0;
      pend_q     <= '0;
      nmi_pend_q <= 1'b0;
      mtime_q    <= '0;
      lpmd_q     <= 2'b11;
      wk_q       <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      nmi_pend_q <= nmi_pend_d;
      wk_q       <= (|pend_q | nmi_pend_q) & (lpmd_q != 2'b11);
      if (clk_en) begin
        prv_q   <= filt_val;
        mtime_q <= pad_cpu_sys_cnt;
        lpmd_q  <= cp0_sysio_lpmd_b;
      end
    end
  end

  assign sysio_clint_irq_pend = pend_q;
  assign sysio_iu_nmi_int     = nmi_pend_q;
  assign sysio_clint_mtime    = mtime_q;
  assign sysio_pad_lpmd_b     = lpmd_q;
  assign sysio_iu_wk_event    = wk_q;

endmodule

// File: tb/tb_cr_sysio_irq_sync.sv
// Directed bench for cr_sysio_irq_sync (default parameters; filter case runs
// only when SYSIO_IRQ_FILTER_EN is defined).
module tb_cr_sysio_irq_sync;

  localparam int IRQ_NUM = 8;
`ifdef SYSIO_IRQ_FILTER_EN
  localparam int FLT = 3;
`else
  localparam int FLT = 0;
`endif
  // Pad rise to pend visible, in clock edges, with clk_en held high.
  localparam int LAT = 3 + FLT;

  logic               clk = 1'b0;
  logic               cpurst;
  logic               clk_en;
  logic [IRQ_NUM-1:0] pad_irq, irq_mode, irq_clr, irq_pend;
  logic               pad_nmi, nmi_ack, nmi_int;
  logic [63:0]        sys_cnt, mtime;
  logic [1:0]         lpmd_in, lpmd_out;
  logic               wk_event;

  int n_tests = 0;
  int n_fail  = 0;

  cr_sysio_irq_sync dut (
    .forever_cpuclk       (clk),
    .cpurst               (cpurst),
    .clk_en               (clk_en),
    .pad_cpu_irq          (pad_irq),
    .cp0_sysio_irq_mode   (irq_mode),
    .cp0_sysio_irq_clr    (irq_clr),
    .sysio_clint_irq_pend (irq_pend),
    .pad_cpu_nmi          (pad_nmi),
    .iu_sysio_nmi_ack     (nmi_ack),
    .sysio_iu_nmi_int     (nmi_int),
    .pad_cpu_sys_cnt      (sys_cnt),
    .sysio_clint_mtime    (mtime),
    .cp0_sysio_lpmd_b     (lpmd_in),
    .sysio_pad_lpmd_b     (lpmd_out),
    .sysio_iu_wk_event    (wk_event)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit so outputs are stable.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cpurst   = 1'b1;
    clk_en   = 1'b1;
    pad_irq  = 8'hFF;
    irq_mode = 8'h08;
    irq_clr  = '0;
    pad_nmi  = 1'b1;
    nmi_ack  = 1'b0;
    sys_cnt  = 64'hDEAD;
    lpmd_in  = 2'b00;

    // Reset with pads toggling
    tick(1);
    pad_irq = 8'h00;
    pad_nmi = 1'b0;
    tick(1);
    check("rst_pend", irq_pend, 0);
    check("rst_nmi", nmi_int, 0);
    check("rst_mtime", mtime, 0);
    check("rst_lpmd", lpmd_out, 2'b11);
    check("rst_wk", wk_event, 0);
    sys_cnt = 64'h0;
    lpmd_in = 2'b11;
    cpurst  = 1'b0;
    tick(LAT + 4);
    check("idle_pend", irq_pend, 0);

    // Level channel 0
    pad_irq[0] = 1'b1;
    tick(LAT - 1);
    check("lvl0_early", irq_pend[0], 0);
    tick(1);
    check("lvl0_rise", irq_pend[0], 1);
    check("lvl0_wk_run", wk_event, 0);
    pad_irq[0] = 1'b0;
    tick(LAT - 1);
    check("lvl0_hold", irq_pend[0], 1);
    tick(1);
    check("lvl0_fall", irq_pend[0], 0);

    // Level channel ignores clr
    pad_irq[1] = 1'b1;
    tick(LAT);
    check("lvl1_rise", irq_pend[1], 1);
    irq_clr[1] = 1'b1;
    tick(1);
    irq_clr[1] = 1'b0;
    check("lvl1_clr_ignored", irq_pend[1], 1);
    pad_irq[1] = 1'b0;
    tick(LAT + 1);
    check("lvl_all_low", irq_pend, 0);

    // Edge channel 3
    pad_irq[3] = 1'b1;
    tick(4);
    pad_irq[3] = 1'b0;
    tick(LAT + 2);
    check("edge3_sticky", irq_pend[3], 1);
    tick(LAT + 2);
    pad_irq[3] = 1'b1;
    tick(LAT - 1);
    irq_clr[3] = 1'b1;
    tick(1);
    irq_clr[3] = 1'b0;
    check("edge3_set_beats_clr", irq_pend[3], 1);
    irq_clr[3] = 1'b1;
    tick(1);
    irq_clr[3] = 1'b0;
    check("edge3_clr", irq_pend[3], 0);
    pad_irq[3] = 1'b0;
    tick(LAT + 4);
    check("edge3_fall_no_set", irq_pend[3], 0);

    // NMI with low-power mode 01
    lpmd_in = 2'b01;
    tick(1);
    check("lpmd_01", lpmd_out, 2'b01);
    check("wk_idle", wk_event, 0);
    pad_nmi = 1'b1;
    tick(LAT - 1);
    check("nmi_early", nmi_int, 0);
    tick(1);
    check("nmi_set", nmi_int, 1);
    check("wk_lag", wk_event, 0);
    tick(1);
    check("wk_nmi", wk_event, 1);
    nmi_ack = 1'b1;
    tick(1);
    nmi_ack = 1'b0;
    check("nmi_ack", nmi_int, 0);
    check("wk_ack_lag", wk_event, 1);
    tick(1);
    check("wk_ack", wk_event, 0);

    // NMI edge coincident with ack
    pad_nmi = 1'b0;
    tick(LAT + 4);
    pad_nmi = 1'b1;
    tick(LAT - 1);
    nmi_ack = 1'b1;
    tick(1);
    nmi_ack = 1'b0;
    check("nmi_set_beats_ack", nmi_int, 1);
    nmi_ack = 1'b1;
    tick(1);
    nmi_ack = 1'b0;
    check("nmi_ack2", nmi_int, 0);
    pad_nmi = 1'b0;
    tick(LAT + 4);

    // clk_en strobing every 4th cycle
    clk_en     = 1'b0;
    sys_cnt    = 64'h1234;
    lpmd_in    = 2'b10;
    pad_irq[3] = 1'b1;
    tick(4);
    check("strb_mtime_hold0", mtime, 64'h0);
    check("strb_lpmd_hold", lpmd_out, 2'b01);
    check("strb_edge_gated", irq_pend[3], 0);
    clk_en = 1'b1;
    tick(1);
    clk_en = 1'b0;
    check("strb_mtime_1234", mtime, 64'h1234);
    check("strb_lpmd_10", lpmd_out, 2'b10);
    sys_cnt = 64'h5678;
    tick(3);
    check("strb_mtime_hold1", mtime, 64'h1234);
    for (int i = 0; i < FLT; i++) begin
      clk_en = 1'b1;
      tick(1);
      clk_en = 1'b0;
      tick(3);
    end
    clk_en = 1'b1;
    tick(1);
    clk_en = 1'b0;
    check("strb_mtime_5678", mtime, 64'h5678);
    check("strb_edge_set", irq_pend[3], 1);
    tick(1);
    check("strb_wk", wk_event, 1);
    irq_clr[3] = 1'b1;
    tick(1);
    irq_clr[3] = 1'b0;
    check("strb_clr_no_en", irq_pend[3], 0);
    clk_en     = 1'b1;
    pad_irq[3] = 1'b0;
    lpmd_in    = 2'b11;
    tick(LAT + 4);

`ifdef SYSIO_IRQ_FILTER_EN
    // Glitch filter on level channel 2
    pad_irq[2] = 1'b1;
    tick(2);
    pad_irq[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("flt_glitch", irq_pend[2], 0);
    end
    pad_irq[2] = 1'b1;
    tick(LAT - 1);
    check("flt_stable_early", irq_pend[2], 0);
    tick(1);
    check("flt_stable", irq_pend[2], 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
